slinky_bus_if: RTL and testbench

//  Apple II slot-bus front end for the SDRAM controller. Decodes the slot's

---
 rtl/slinky_bus_if.sv | 165 ++++++++++++++++
 tb/tb_slinky_bus_if.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slinky_bus_if.sv
// slinky_bus_if: Apple II slot-bus front end for the SDRAM controller.
// Decodes a Slinky-style window: $C0n0-$C0n2 hold a 24-bit auto-increment
// pointer and $C0n3 is the data port. Reads are prefetched: the SDRAM read
// for the next data byte runs during the bus cycle after the one that asked.
module slinky_bus_if #(
  parameter int ABITS     = 24,
  parameter int INIT_SKIP = 1
) (
  input  logic        C8M,
  input  logic        nRESET,
  input  logic        PHI2,
  input  logic        nDEVSEL,
  input  logic        RnW,
  input  logic [3:0]  BA,
  input  logic [7:0]  BDI,
  output logic [7:0]  BDO,
  output logic        BDOE,
  output logic        RDCMD,
  output logic        WRCMD,
  output logic [23:0] A,
  output logic [7:0]  WRD,
  input  logic [7:0]  RDD
);

  // PHI2 synchroniser plus history flop for edge detection
  logic r_phi2_meta, r_phi2_s, r_phi2_d;

  // Bus cycle snapshot, refreshed while synchronised PHI2 is high
  logic       r_lat_ndevsel;
  logic       r_lat_rnw;
  logic [3:0] r_lat_ba;
  logic [7:0] r_lat_bdi;

  // Window state
  logic [ABITS-1:0] r_ptr;
  logic [23:0]      r_a;
  logic [7:0]       r_wrd;
  logic [7:0]       r_dbuf;
  logic [7:0]       r_bdo;
  logic             r_bdoe;
  logic             r_rdcmd;
  logic             r_wrcmd;
  logic             r_pend;
  logic [7:0]       r_skip;

  logic             w_pf;
  logic             w_hit;
  logic [ABITS-1:0] w_ptr_inc;
  logic [23:0]      w_ptr24;
  logic [23:0]      w_inc24;
  logic [23:0]      w_ptr_load;

  assign w_pf      = r_phi2_d & ~r_phi2_s;
  assign w_hit     = ~r_lat_ndevsel && (r_lat_ba < 4'd4);
  assign w_ptr_inc = r_ptr + ABITS'(1);
  // Unimplemented pointer bits read as zero
  assign w_ptr24   = 24'(r_ptr);
  assign w_inc24   = 24'(w_ptr_inc);

  // Pointer with one byte replaced by the latched write data (no carry)
  always_comb begin
    w_ptr_load = w_ptr24;
    case (r_lat_ba[1:0])
      2'd0:    w_ptr_load[7:0]   = r_lat_bdi;
      2'd1:    w_ptr_load[15:8]  = r_lat_bdi;
      2'd2:    w_ptr_load[23:16] = r_lat_bdi;
      default: w_ptr_load        = w_ptr24;
    endcase
  end

  // Bring PHI2 into the C8M domain
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      r_phi2_meta <= 1'b0;
      r_phi2_s    <= 1'b0;
      r_phi2_d    <= 1'b0;
    end else begin
      r_phi2_meta <= PHI2;
      r_phi2_s    <= r_phi2_meta;
      r_phi2_d    <= r_phi2_s;
    end
  end

  // Snapshot the bus while PHI2 is high; the last snapshot defines the cycle
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      r_lat_ndevsel <= 1'b1;
      r_lat_rnw     <= 1'b1;
      r_lat_ba      <= 4'd0;
      r_lat_bdi     <= 8'd0;
    end else if (r_phi2_s) begin
      r_lat_ndevsel <= nDEVSEL;
      r_lat_rnw     <= RnW;
      r_lat_ba      <= BA;
      r_lat_bdi     <= BDI;
    end
  end

  // Read-data drive: enable only for a selected read of $0-$3 during PHI2 high
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      r_bdoe <= 1'b0;
      r_bdo  <= 8'd0;
    end else begin
      r_bdoe <= r_phi2_s && !nDEVSEL && RnW && (BA < 4'd4);
      case (BA[1:0])
        2'd0:    r_bdo <= w_ptr24[7:0];
        2'd1:    r_bdo <= w_ptr24[15:8];
        2'd2:    r_bdo <= w_ptr24[23:16];
        default: r_bdo <= r_dbuf;
      endcase
    end
  end

  // On each PHI2 fall: close the command window, then act on the finished cycle
  always_ff @(posedge C8M or negedge nRESET) begin
    if (!nRESET) begin
      r_ptr   <= '0;
      r_a     <= 24'd0;
      r_wrd   <= 8'd0;
      r_dbuf  <= 8'd0;
      r_rdcmd <= 1'b0;
      r_wrcmd <= 1'b0;
      r_pend  <= 1'b1;
      r_skip  <= 8'(INIT_SKIP);
    end else if (w_pf) begin
      if (r_rdcmd)
        r_dbuf <= RDD;
      r_rdcmd <= 1'b0;
      r_wrcmd <= 1'b0;
      if (r_skip != 8'd0) begin
        // Controller still initialising: swallow this cycle entirely
        r_skip <= r_skip - 8'd1;
      end else if (w_hit && !r_lat_rnw && (r_lat_ba != 4'd3)) begin
        r_ptr  <= w_ptr_load[ABITS-1:0];
        r_pend <= 1'b1;
      end else if (w_hit && r_lat_rnw && (r_lat_ba == 4'd3)) begin
        // Data just returned came from the prefetch; fetch the next byte
        r_ptr   <= w_ptr_inc;
        r_a     <= w_inc24;
        r_rdcmd <= 1'b1;
        r_pend  <= 1'b0;
      end else if (w_hit && !r_lat_rnw && (r_lat_ba == 4'd3)) begin
        r_a     <= w_ptr24;
        r_wrd   <= r_lat_bdi;
        r_wrcmd <= 1'b1;
        r_ptr   <= w_ptr_inc;
        r_pend  <= 1'b1;
      end else if (r_pend) begin
        // Idle or pointer-read cycle: refill the prefetch buffer
        r_a     <= w_ptr24;
        r_rdcmd <= 1'b1;
        r_pend  <= 1'b0;
      end
    end
  end

  assign BDO   = r_bdo;
  assign BDOE  = r_bdoe;
  assign RDCMD = r_rdcmd;
  assign WRCMD = r_wrcmd;
  assign A     = r_a;
  assign WRD   = r_wrd;

endmodule

// File: tb/tb_slinky_bus_if.sv
// tb_slinky_bus_if: directed bus cycles against slinky_bus_if, with a
// 20-bit-pointer instance alongside to exercise the narrow pointer.
module tb_slinky_bus_if;

  logic        C8M = 1'b0;
  logic        nRESET = 1'b0;
  logic        PHI2 = 1'b0;
  logic        nDEVSEL = 1'b1;
  logic        RnW = 1'b1;
  logic [3:0]  BA = 4'hF;
  logic [7:0]  BDI = 8'h00;
  logic [7:0]  RDD = 8'h00;
  logic [7:0]  BDO, BDO20;
  logic        BDOE, BDOE20;
  logic        RDCMD, RDCMD20;
  logic        WRCMD, WRCMD20;
  logic [23:0] A, A20;
  logic [7:0]  WRD, WRD20;

  int n_checks = 0;
  int n_errors = 0;

  logic       seen_bdoe;
  logic [7:0] seen_bdo;
  logic [7:0] seen_bdo20;

  slinky_bus_if dut (
    .C8M(C8M), .nRESET(nRESET), .PHI2(PHI2), .nDEVSEL(nDEVSEL), .RnW(RnW),
    .BA(BA), .BDI(BDI), .BDO(BDO), .BDOE(BDOE), .RDCMD(RDCMD), .WRCMD(WRCMD),
    .A(A), .WRD(WRD), .RDD(RDD)
  );

  slinky_bus_if #(.ABITS(20)) dut20 (
    .C8M(C8M), .nRESET(nRESET), .PHI2(PHI2), .nDEVSEL(nDEVSEL), .RnW(RnW),
    .BA(BA), .BDI(BDI), .BDO(BDO20), .BDOE(BDOE20), .RDCMD(RDCMD20), .WRCMD(WRCMD20),
    .A(A20), .WRD(WRD20), .RDD(RDD)
  );

  always #5 C8M = ~C8M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One 1 MHz bus cycle: 4 C8M high, 4 C8M low; returns after the PHI2 fall is processed
  task automatic bus_cycle(input logic nd, input logic rnw, input logic [3:0] ba, input logic [7:0] bdi);
    nDEVSEL = nd; RnW = rnw; BA = ba; BDI = bdi; PHI2 = 1'b1;
    repeat (4) @(negedge C8M);
    seen_bdoe  = BDOE;
    seen_bdo   = BDO;
    seen_bdo20 = BDO20;
    PHI2 = 1'b0;
    repeat (4) @(negedge C8M);
  endtask

  task automatic idle();
    bus_cycle(1'b1, 1'b1, 4'hF, 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge C8M);
    check("rst_bdo", BDO, 8'h00);
    check("rst_bdoe", BDOE, 1'b0);
    check("rst_rdcmd", RDCMD, 1'b0);
    check("rst_wrcmd", WRCMD, 1'b0);
    check("rst_a", A, 24'h0);
    check("rst_wrd", WRD, 8'h00);
    nRESET = 1'b1;
    repeat (2) @(negedge C8M);

    // 1: first PF skipped, second issues the initial prefetch, third is quiet
    idle();
    check("t1_pf1_rdcmd", RDCMD, 1'b0);
    idle();
    check("t1_pf2_rdcmd", RDCMD, 1'b1);
    check("t1_pf2_a", A, 24'h0);
    check("t1_pf2_wrcmd", WRCMD, 1'b0);
    idle();
    check("t1_pf3_rdcmd", RDCMD, 1'b0);

    // 2: load pointer, idle prefetch, RDD lands in DBUF
    bus_cycle(1'b0, 1'b0, 4'h0, 8'h34);
    check("t2_wr0_bdoe", seen_bdoe, 1'b0);
    bus_cycle(1'b0, 1'b0, 4'h1, 8'h12);
    bus_cycle(1'b0, 1'b0, 4'h2, 8'h05);
    check("t2_wr2_rdcmd", RDCMD, 1'b0);
    check("t2_wr2_wrcmd", WRCMD, 1'b0);
    idle();
    check("t2_idle_rdcmd", RDCMD, 1'b1);
    check("t2_idle_a", A, 24'h051234);
    RDD = 8'hA5;
    idle();
    check("t2_idle2_rdcmd", RDCMD, 1'b0);
    RDD = 8'h00;

    // 3: data read returns DBUF and prefetches the next byte
    bus_cycle(1'b0, 1'b1, 4'h3, 8'h00);
    check("t3_bdo", seen_bdo, 8'hA5);
    check("t3_bdoe_hi", seen_bdoe, 1'b1);
    check("t3_bdoe_lo", BDOE, 1'b0);
    check("t3_rdcmd", RDCMD, 1'b1);
    check("t3_a", A, 24'h051235);

    // 4: data write then idle refill at the incremented pointer
    bus_cycle(1'b0, 1'b0, 4'h0, 8'h10);
    bus_cycle(1'b0, 1'b0, 4'h1, 8'h00);
    bus_cycle(1'b0, 1'b0, 4'h2, 8'h00);
    bus_cycle(1'b0, 1'b0, 4'h3, 8'h5A);
    check("t4_wrcmd", WRCMD, 1'b1);
    check("t4_rdcmd", RDCMD, 1'b0);
    check("t4_a", A, 24'h000010);
    check("t4_wrd", WRD, 8'h5A);
    idle();
    check("t4_idle_wrcmd", WRCMD, 1'b0);
    check("t4_idle_rdcmd", RDCMD, 1'b1);
    check("t4_idle_a", A, 24'h000011);
    idle();

    // 5: pointer wrap and narrow pointer readback
    bus_cycle(1'b0, 1'b0, 4'h0, 8'hFF);
    bus_cycle(1'b0, 1'b0, 4'h1, 8'hFF);
    bus_cycle(1'b0, 1'b0, 4'h2, 8'hFF);
    bus_cycle(1'b0, 1'b1, 4'h2, 8'h00);
    check("t5_rd2_bdo", seen_bdo, 8'hFF);
    check("t5_rd2_bdo20", seen_bdo20, 8'h0F);
    check("t5_rd2_a", A, 24'hFFFFFF);
    check("t5_rd2_a20", A20, 24'h0FFFFF);
    check("t5_rd2_rdcmd", RDCMD, 1'b1);
    idle();
    bus_cycle(1'b0, 1'b1, 4'h3, 8'h00);
    check("t5_wrap_rdcmd", RDCMD, 1'b1);
    check("t5_wrap_a", A, 24'h000000);
    check("t5_wrap_a20", A20, 24'h000000);
    bus_cycle(1'b0, 1'b1, 4'h0, 8'h00);
    check("t5_rd0_bdo", seen_bdo, 8'h00);
    bus_cycle(1'b0, 1'b1, 4'h5, 8'h00);
    check("t5_ba5_bdoe", seen_bdoe, 1'b0);

    // 6: async reset in the middle of a write window
    bus_cycle(1'b0, 1'b0, 4'h0, 8'h42);
    bus_cycle(1'b0, 1'b0, 4'h3, 8'h77);
    check("t6_wrcmd", WRCMD, 1'b1);
    check("t6_a", A, 24'h000042);
    check("t6_wrd", WRD, 8'h77);
    nDEVSEL = 1'b0; RnW = 1'b1; BA = 4'h1; PHI2 = 1'b1;
    repeat (4) @(negedge C8M);
    check("t6_pre_bdoe", BDOE, 1'b1);
    check("t6_pre_wrcmd", WRCMD, 1'b1);
    #1 nRESET = 1'b0;
    #1;
    check("t6_async_wrcmd", WRCMD, 1'b0);
    check("t6_async_bdoe", BDOE, 1'b0);
    check("t6_async_a", A, 24'h0);
    check("t6_async_wrd", WRD, 8'h00);
    check("t6_async_bdo", BDO, 8'h00);
    PHI2 = 1'b0; nDEVSEL = 1'b1;
    repeat (4) @(negedge C8M);
    nRESET = 1'b1;
    repeat (2) @(negedge C8M);
    idle();
    check("t6_skip_rdcmd", RDCMD, 1'b0);
    idle();
    check("t6_pf2_rdcmd", RDCMD, 1'b1);
    check("t6_pf2_a", A, 24'h0);
    RDD = 8'hC3;
    bus_cycle(1'b0, 1'b1, 4'h3, 8'h00);
    check("t6_dbuf_rst", seen_bdo, 8'h00);
    check("t6_rd3_a", A, 24'h000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
